serial_demux7: RTL and testbench
================================

# serial_demux7

Sequential 1-to-7 demultiplexer / serial-to-parallel capture block: the receive-side counterpart of the 7:1 bit-select multiplexer. It assembles a frame of serial bits into a 7-bit parallel word. An internal slot counter steers each accepted bit to its slot, and the word is published with a one-cycle valid pulse when the frame completes. It sits between a serial source (switch/key-driven or a counter-driven mux serializer) and parallel consumers such as LEDR or HEX decoders.

## Interface
- SLOTS, default 7: number of bits per frame; legal 1..7. Output bits at index >= SLOTS are always 0.
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a new frame: clears the shadow word and sets ptr to 0. Aborts any frame in progress.
- din  in  1  serial data bit.
- din_valid  in  1  din is sampled on this cycle when the block is in SHIFT.
- out  out  7  last completed word; bit i = i-th accepted bit of the frame. Registered, and held between completions.
- out_valid  out  1  one-cycle pulse: out was updated this cycle.
- busy  out  1  high while in SHIFT.
- ptr  out  3  slot index the next accepted bit will be written to (0..SLOTS-1).
- err  out  1  sticky: din_valid arrived while not in SHIFT and without start. Cleared by start or reset.

## Operation
- States:
  - IDLE: waits for start.
  - SHIFT: accepts bits.
  - DONE: one cycle; out_valid=1.
- IDLE:
  - start=1 -> SHIFT, ptr<=0, shadow<=0.
  - din_valid=1 with start=0 -> err<=1.
  - Otherwise stay in IDLE.
- SHIFT:
  - start=1 has priority: restart the frame (ptr<=0, shadow<=0, stay in SHIFT). The din bit is dropped and no out_valid is produced.
  - din_valid=1, start=0: shadow[ptr]<=din.
    - If ptr==SLOTS-1: out<=shadow with the new bit merged, unused bits forced 0, then go to DONE and ptr<=0.
    - Otherwise ptr<=ptr+1.
  - din_valid=0: hold; gaps of any length are allowed.
- DONE: out_valid=1 for exactly this cycle.
  - start=1 -> SHIFT (frame cleared as above).
  - Otherwise -> IDLE.
  - din_valid=1 with start=0 -> err<=1; the bit is dropped.
- Demux rule: only the addressed shadow bit changes per accepted bit. Other bits hold.
- ptr never reaches a value >= SLOTS. Slot index 7 is never written, which mirrors the mux default.
- out changes only when a frame completes. Aborted frames never reach out.

## Timing
- Reset values: state IDLE, out=7'b0, out_valid=0, busy=0, ptr=0, err=0, shadow=0.
- Reset wins over all other inputs in the same cycle. Reset mid-frame discards the partial frame; out returns to 0.
- Latency:
  - start sampled at edge N gives busy=1 after edge N.
  - Bits are accepted at edges N+1 .. N+SLOTS when din_valid is held high.
  - out and out_valid update after edge N+SLOTS; out_valid is high during the following cycle.
- Back-to-back frames: asserting start during DONE gives busy=1 the next cycle, so there is one dead cycle between frames.
- start and din_valid in the same cycle: the bit is never captured in any state.
- busy is low in DONE.
- err sets on the edge that samples the offending din_valid, and clears on the edge that samples start.

## Test plan
- Reset, then idle for 5 cycles -> out=0, out_valid=0, busy=0, ptr=0, err=0 throughout.
- start, then din = 1,0,1,1,0,0,1 on consecutive valid cycles -> out=7'b1001101 with a single out_valid pulse 8 cycles after start, then busy=0.
- Same frame with din_valid low for 3 cycles after bit 3 -> same out=7'b1001101. out_valid is delayed by exactly 3 cycles and ptr holds at 3 during the gap.
- start, 4 bits 1,1,1,1, then start again, then 7 bits all 0 -> no out_valid after the aborted frame. The final out=7'b0000000 with one pulse; out's prior value is held until then.
- SLOTS=3: start, din=1,1,1 -> out=7'b0000111 after 3 bits. ptr sequence is 0,1,2,0.
- din_valid=1 in IDLE (no start) -> err=1 and out unchanged. A subsequent start clears err; a start with din_valid=1 in the same cycle leaves shadow bit 0 unwritten.

Source files
------------

// File: rtl/serial_demux7.sv
// Serial-to-parallel capture: steers each accepted serial bit into its frame slot
// and publishes the completed word with a one-cycle valid pulse.
module serial_demux7 #(
    parameter int unsigned SLOTS = 7
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       din_i,
    input  logic       din_valid_i,
    output logic [6:0] out_o,
    output logic       out_valid_o,
    output logic       busy_o,
    output logic [2:0] ptr_o,
    output logic       err_o
);

    localparam int unsigned W  = 7;
    localparam int unsigned PW = 3;
    localparam logic [PW-1:0] LAST = PW'(SLOTS - 1);
    localparam logic [W-1:0]  MASK = W'((8'd1 << SLOTS) - 8'd1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    shadow_q;
    logic [W-1:0]    shadow_d;
    logic [W-1:0]    out_q;
    logic            out_valid_q;
    logic            busy_q;
    logic [PW-1:0]   ptr_q;
    logic            err_q;

    // Shadow word with the incoming bit written to the addressed slot only.
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < int'(W); i++) begin
            if (PW'(i) == ptr_q) begin
                shadow_d[i] = din_i;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            shadow_q    <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            ptr_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        state_q  <= S_SHIFT;
                        busy_q   <= 1'b1;
                        ptr_q    <= '0;
                        shadow_q <= '0;
                        err_q    <= 1'b0;
                    end else begin
                        state_q <= S_IDLE;
                        if (din_valid_i) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    // A restart drops any bit presented alongside it.
                    if (start_i) begin
                        ptr_q    <= '0;
                        shadow_q <= '0;
                        err_q    <= 1'b0;
                    end else if (din_valid_i) begin
                        shadow_q <= shadow_d;
                        if (ptr_q == LAST) begin
                            out_q       <= shadow_d & MASK;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                            busy_q      <= 1'b0;
                            ptr_q       <= '0;
                        end else begin
                            ptr_q <= ptr_q + PW'(1);
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ptr_q   <= '0;
                end
            endcase
        end
    end

    assign out_o       = out_q;
    assign out_valid_o = out_valid_q;
    assign busy_o      = busy_q;
    assign ptr_o       = ptr_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_serial_demux7.sv
// Bench for serial_demux7: directed scenarios plus randomized traffic against a
// frame-level reference model (bit queue, word built by arithmetic).
module tb_serial_demux7;

    logic       clk = 1'b0;
    logic       rst, start, dv, din;
    logic [6:0] out;
    logic       ov, busy, err;
    logic [2:0] ptr;

    logic       s3_start, s3_dv, s3_din;
    logic [6:0] s3_out;
    logic       s3_ov, s3_busy, s3_err;
    logic [2:0] s3_ptr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame in progress, queue of accepted bits, published word.
    bit         m_active, m_done, m_err;
    bit         m_bits[$];
    logic [6:0] m_out;

    always #5 clk = ~clk;

    serial_demux7 #(.SLOTS(7)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .din_i(din),
        .din_valid_i(dv), .out_o(out), .out_valid_o(ov), .busy_o(busy),
        .ptr_o(ptr), .err_o(err)
    );

    serial_demux7 #(.SLOTS(3)) dut3 (
        .clock_i(clk), .reset_i(rst), .start_i(s3_start), .din_i(s3_din),
        .din_valid_i(s3_dv), .out_o(s3_out), .out_valid_o(s3_ov), .busy_o(s3_busy),
        .ptr_o(s3_ptr), .err_o(s3_err)
    );

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        m_bits.delete();
        m_out    = '0;
    endtask

    task automatic model_step(input bit s, input bit v, input bit d);
        int acc;
        if (s) begin
            m_bits.delete();
            m_active = 1'b1;
            m_done   = 1'b0;
            m_err    = 1'b0;
        end else if (m_active) begin
            m_done = 1'b0;
            if (v) begin
                m_bits.push_back(d);
                if (m_bits.size() == 7) begin
                    acc = 0;
                    foreach (m_bits[i]) acc += int'(m_bits[i]) * (1 << i);
                    m_out    = 7'(acc);
                    m_done   = 1'b1;
                    m_active = 1'b0;
                    m_bits.delete();
                end
            end
        end else begin
            m_done = 1'b0;
            if (v) m_err = 1'b1;
        end
    endtask

    // One clock on the SLOTS=7 instance; outputs are settled when this returns.
    task automatic cycle(input bit s, input bit v, input bit d, input bit r);
        start = s; dv = v; din = d; rst = r;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_step(s, v, d);
        start = 1'b0; dv = 1'b0; din = 1'b0; rst = 1'b0;
    endtask

    task automatic cycle3(input bit s, input bit v, input bit d);
        s3_start = s; s3_dv = v; s3_din = d;
        @(posedge clk);
        #1;
        model_step(1'b0, 1'b0, 1'b0);
        s3_start = 1'b0; s3_dv = 1'b0; s3_din = 1'b0;
    endtask

    task automatic test_reset();
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            n_tests++;
            if ({out, ov, busy, ptr, err} !== 13'b0 || {s3_out, s3_ov, s3_busy, s3_ptr, s3_err} !== 13'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: out=%b ov=%b busy=%b ptr=%0d err=%b (s3 out=%b) want all 0",
                         i, out, ov, busy, ptr, err, s3_out);
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [6:0] pat = 7'b1001101;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || ptr !== 3'd0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_start: busy=%b ptr=%0d ov=%b want 1 0 0", busy, ptr, ov);
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, pat[i], 1'b0);
            n_tests++;
            if (i < 6) begin
                if (ov !== 1'b0 || ptr !== 3'(i + 1) || busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL basic_bit%0d: ov=%b ptr=%0d busy=%b want 0 %0d 1", i, ov, ptr, busy, i + 1);
                end
            end else if (ov !== 1'b1 || out !== pat || busy !== 1'b0 || ptr !== 3'd0) begin
                n_fail++;
                $display("FAIL basic_done: ov=%b out=%b busy=%b ptr=%0d want 1 %b 0 0", ov, out, busy, ptr, pat);
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (ov !== 1'b0 || out !== pat || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_after: ov=%b out=%b busy=%b want 0 %b 0", ov, out, busy, pat);
        end
    endtask

    task automatic test_gap();
        logic [6:0] pat = 7'b1001101;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, pat[i], 1'b0);
        for (int g = 0; g < 3; g++) begin
            cycle(1'b0, 1'b0, 1'b1, 1'b0);
            n_tests++;
            if (ptr !== 3'd3 || ov !== 1'b0 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL gap_hold%0d: ptr=%0d ov=%b busy=%b want 3 0 1", g, ptr, ov, busy);
            end
        end
        for (int i = 3; i < 7; i++) begin
            cycle(1'b0, 1'b1, pat[i], 1'b0);
            n_tests++;
            if (ov !== ((i == 6) ? 1'b1 : 1'b0) || (i == 6 && out !== pat)) begin
                n_fail++;
                $display("FAIL gap_bit%0d: ov=%b out=%b want ov=%0d out=%b", i, ov, out, i == 6, pat);
            end
        end
    endtask

    task automatic test_abort();
        logic [6:0] prev = 7'b1001101;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (ptr !== 3'd0 || busy !== 1'b1 || ov !== 1'b0 || out !== prev) begin
            n_fail++;
            $display("FAIL abort_restart: ptr=%0d busy=%b ov=%b out=%b want 0 1 0 %b", ptr, busy, ov, out, prev);
        end
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0);
            n_tests++;
            if (i < 6 && (ov !== 1'b0 || out !== prev)) begin
                n_fail++;
                $display("FAIL abort_hold%0d: ov=%b out=%b want 0 %b", i, ov, out, prev);
            end else if (i == 6 && (ov !== 1'b1 || out !== 7'b0)) begin
                n_fail++;
                $display("FAIL abort_done: ov=%b out=%b want 1 0000000", ov, out);
            end
        end
    endtask

    task automatic test_idle_err();
        logic [6:0] w = 7'($urandom);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (err !== 1'b1 || out !== 7'b0 || busy !== 1'b0 || ov !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_err_set: err=%b out=%b busy=%b ov=%b want 1 0 0 0", err, out, busy, ov);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL idle_err_sticky: err=%b want 1", err);
        end
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (err !== 1'b0 || ptr !== 3'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_clears_err: err=%b ptr=%0d busy=%b want 0 0 1", err, ptr, busy);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, w[i], 1'b0);
        n_tests++;
        if (ov !== 1'b1 || out !== w) begin
            n_fail++;
            $display("FAIL post_err_frame: ov=%b out=%b want 1 %b", ov, out, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] w = 7'($urandom);
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (busy !== 1'b1 || ptr !== 3'd0 || ov !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_start_in_done: busy=%b ptr=%0d ov=%b err=%b want 1 0 0 0", busy, ptr, ov, err);
        end
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, w[i], 1'b0);
        n_tests++;
        if (ov !== 1'b1 || out !== w) begin
            n_fail++;
            $display("FAIL b2b_frame: ov=%b out=%b want 1 %b", ov, out, w);
        end
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (err !== 1'b1 || busy !== 1'b0 || ov !== 1'b0 || out !== w) begin
            n_fail++;
            $display("FAIL done_err: err=%b busy=%b ov=%b out=%b want 1 0 0 %b", err, busy, ov, out, w);
        end
    endtask

    task automatic test_slots3();
        logic [2:0] want_ptr [3] = '{3'd1, 3'd2, 3'd0};
        cycle3(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (s3_ptr !== 3'd0 || s3_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL s3_start: ptr=%0d busy=%b want 0 1", s3_ptr, s3_busy);
        end
        for (int i = 0; i < 3; i++) begin
            cycle3(1'b0, 1'b1, 1'b1);
            n_tests++;
            if (s3_ptr !== want_ptr[i] || s3_ov !== ((i == 2) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL s3_bit%0d: ptr=%0d ov=%b want %0d %0d", i, s3_ptr, s3_ov, want_ptr[i], i == 2);
            end
        end
        n_tests++;
        if (s3_out !== 7'b0000111 || s3_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL s3_out: out=%b busy=%b want 0000111 0", s3_out, s3_busy);
        end
    endtask

    task automatic test_random();
        bit s, v, d, r;
        logic [12:0] want;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 11) == 0);
            v = ($urandom_range(0, 9) < 7);
            d = 1'($urandom);
            cycle(s, v, d, r);
            want = {m_out, m_done, m_active, 3'(m_bits.size()), m_err};
            n_tests++;
            if ({out, ov, busy, ptr, err} !== want) begin
                n_fail++;
                $display("FAIL random c%0d: out=%b ov=%b busy=%b ptr=%0d err=%b want out=%b ov=%b busy=%b ptr=%0d err=%b",
                         c, out, ov, busy, ptr, err, want[12:6], want[5], want[4], want[3:1], want[0]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; dv = 1'b0; din = 1'b0;
        s3_start = 1'b0; s3_dv = 1'b0; s3_din = 1'b0;
        model_reset();
        test_reset();
        test_basic_frame();
        test_gap();
        test_abort();
        test_idle_err();
        test_back_to_back();
        test_slots3();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
